bcd_time_keeper: RTL and testbench

//  Timekeeping stage feeding the 7-segment clock display decoder. Divides clk down to a
//  1 Hz tick and keeps time of day as BCD digits HH:MM:SS (24 h internally). Presents
//  12 h or 24 h hours on request. Has a button-driven set mode for hours and minutes.

---
 rtl/bcd_time_keeper_pkg.sv | 47 ++++
 rtl/bcd_time_keeper_if.sv | 32 +++
 rtl/bcd_time_keeper_bcd_mod_counter.sv | 42 ++++
 rtl/bcd_time_keeper.sv | 174 +++++++++++++++++
 tb/tb_bcd_time_keeper.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_time_keeper_pkg.sv
// Shared types and constants for the BCD time-of-day keeper.
// Holds the FSM state codes, edit-field codes, field moduli and the 12 h hour mapping helper.
package bcd_time_keeper_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [1:0] edit_field_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd2_t;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_SET_HR  = 2'd1;
  localparam logic [1:0] ST_SET_MIN = 2'd2;

  localparam edit_field_t EDIT_NONE = 2'b00;
  localparam edit_field_t EDIT_HR   = 2'b01;
  localparam edit_field_t EDIT_MIN  = 2'b10;

  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;
  localparam int HR_MOD  = 24;

  // 24 h BCD hour to 12 h BCD hour, done digit-wise: 00->12, 13..23 -> 01..11.
  function automatic bcd2_t to_12h(input bcd2_t h);
    bcd2_t r;
    r = h;
    if (h.tens == 4'd0 && h.ones == 4'd0) begin
      r.tens = 4'd1;
      r.ones = 4'd2;
    end else if (h.tens == 4'd1 && h.ones >= 4'd3) begin
      r.tens = 4'd0;
      r.ones = h.ones - 4'd2;
    end else if (h.tens == 4'd2) begin
      if (h.ones <= 4'd1) begin
        r.tens = 4'd0;
        r.ones = h.ones + 4'd8;
      end else begin
        r.tens = 4'd1;
        r.ones = h.ones - 4'd2;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_time_keeper_if.sv
// Display-side bundle: hour-format and button inputs plus the registered BCD time and status.
// The master drives the buttons and format select; the slave (time keeper) drives everything else.
interface bcd_time_keeper_if;
  import bcd_time_keeper_pkg::*;

  logic        mode_12h;
  logic        btn_mode;
  logic        btn_inc;
  bcd_t        sec_ones;
  bcd_t        sec_tens;
  bcd_t        min_ones;
  bcd_t        min_tens;
  bcd_t        hr_ones;
  bcd_t        hr_tens;
  logic        pm;
  logic        sec_tick;
  edit_field_t edit_field;
  logic        blink;

  modport master (
    output mode_12h, btn_mode, btn_inc,
    input  sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens,
    input  pm, sec_tick, edit_field, blink
  );

  modport slave (
    input  mode_12h, btn_mode, btn_inc,
    output sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens,
    output pm, sec_tick, edit_field, blink
  );

endinterface

// File: rtl/bcd_time_keeper_bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MOD; updates on the clock after inc, clr has priority.
// carry_out is combinational and pulses during the cycle in which the wrap is taken; no stall.
module bcd_mod_counter
  import bcd_time_keeper_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output bcd_t ones,
  output bcd_t tens,
  output logic carry_out
);

  localparam bcd_t MAX_ONES = bcd_t'((MOD - 1) % 10);
  localparam bcd_t MAX_TENS = bcd_t'((MOD - 1) / 10);

  logic at_max;

  assign at_max    = (ones == MAX_ONES) && (tens == MAX_TENS);
  assign carry_out = inc && !clr && at_max;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (inc) begin
      if (at_max) begin
        ones <= 4'd0;
        tens <= 4'd0;
      end else if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_time_keeper.sv
// 1 Hz BCD time-of-day keeper with hour/minute set mode; outputs are registered one cycle after state.
// No backpressure: buttons are level inputs sampled every cycle, outputs are always valid.
module bcd_time_keeper
  import bcd_time_keeper_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BLINK_DIV = 2
) (
  input logic              clk,
  input logic              reset,
  bcd_time_keeper_if.slave tk
);

  localparam int PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BLINK_HALF = (CLK_HZ / BLINK_DIV > 0) ? CLK_HZ / BLINK_DIV : 1;
  localparam int BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          btn_mode_q;
  logic          btn_inc_q;
  logic          mode_edge;
  logic          inc_edge;
  logic          tick;
  logic          tick_r;
  logic          leave_set;
  logic          hr_set_inc;
  logic          min_set_inc;

  bcd_t          sec_ones_i, sec_tens_i;
  bcd_t          min_ones_i, min_tens_i;
  bcd_t          hr_ones_i, hr_tens_i;
  logic          sec_carry;
  logic          min_carry;
  logic          unused_hr_carry;

  bcd2_t         hr_disp;
  logic          pm_i;
  edit_field_t   edit_i;

  assign mode_edge   = tk.btn_mode && !btn_mode_q;
  assign inc_edge    = tk.btn_inc && !btn_inc_q;
  assign tick        = (state == ST_RUN) && (presc == PW'(CLK_HZ - 1));
  assign leave_set   = (state == ST_SET_MIN) && mode_edge;
  // A mode edge swallows a coincident inc edge.
  assign hr_set_inc  = (state == ST_SET_HR) && inc_edge && !mode_edge;
  assign min_set_inc = (state == ST_SET_MIN) && inc_edge && !mode_edge;

  always_comb begin
    state_nxt = state;
    if (mode_edge) begin
      case (state)
        ST_RUN:    state_nxt = ST_SET_HR;
        ST_SET_HR: state_nxt = ST_SET_MIN;
        default:   state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      btn_mode_q <= 1'b0;
      btn_inc_q  <= 1'b0;
      tick_r     <= 1'b0;
    end else begin
      state      <= state_nxt;
      btn_mode_q <= tk.btn_mode;
      btn_inc_q  <= tk.btn_inc;
      tick_r     <= tick;
    end
  end

  // Prescaler runs only in RUN; leaving set mode restarts a full second.
  always_ff @(posedge clk) begin
    if (reset || leave_set) begin
      presc <= '0;
    end else if (state == ST_RUN) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (state_nxt != state)) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (state != ST_RUN) begin
      if (blink_cnt == BW'(BLINK_HALF - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= !blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end else begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end
  end

  bcd_mod_counter #(.MOD(SEC_MOD)) u_sec (
    .clk       (clk),
    .reset     (reset),
    .inc       (tick),
    .clr       (leave_set),
    .ones      (sec_ones_i),
    .tens      (sec_tens_i),
    .carry_out (sec_carry)
  );

  bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
    .clk       (clk),
    .reset     (reset),
    .inc       (sec_carry || min_set_inc),
    .clr       (1'b0),
    .ones      (min_ones_i),
    .tens      (min_tens_i),
    .carry_out (min_carry)
  );

  // Minute wraps made while setting must not ripple into the hour.
  bcd_mod_counter #(.MOD(HR_MOD)) u_hr (
    .clk       (clk),
    .reset     (reset),
    .inc       (((state == ST_RUN) && min_carry) || hr_set_inc),
    .clr       (1'b0),
    .ones      (hr_ones_i),
    .tens      (hr_tens_i),
    .carry_out (unused_hr_carry)
  );

  always_comb begin
    hr_disp.tens = hr_tens_i;
    hr_disp.ones = hr_ones_i;
    if (tk.mode_12h) begin
      hr_disp = to_12h(hr_disp);
    end
    pm_i = (hr_tens_i == 4'd2) || ((hr_tens_i == 4'd1) && (hr_ones_i >= 4'd2));
    case (state)
      ST_SET_HR:  edit_i = EDIT_HR;
      ST_SET_MIN: edit_i = EDIT_MIN;
      default:    edit_i = EDIT_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tk.sec_ones   <= 4'd0;
      tk.sec_tens   <= 4'd0;
      tk.min_ones   <= 4'd0;
      tk.min_tens   <= 4'd0;
      tk.hr_tens    <= tk.mode_12h ? 4'd1 : 4'd0;
      tk.hr_ones    <= tk.mode_12h ? 4'd2 : 4'd0;
      tk.pm         <= 1'b0;
      tk.sec_tick   <= 1'b0;
      tk.edit_field <= EDIT_NONE;
      tk.blink      <= 1'b0;
    end else begin
      tk.sec_ones   <= sec_ones_i;
      tk.sec_tens   <= sec_tens_i;
      tk.min_ones   <= min_ones_i;
      tk.min_tens   <= min_tens_i;
      tk.hr_tens    <= hr_disp.tens;
      tk.hr_ones    <= hr_disp.ones;
      tk.pm         <= pm_i;
      tk.sec_tick   <= tick_r;
      tk.edit_field <= edit_i;
      tk.blink      <= (state != ST_RUN) && blink_phase;
    end
  end

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Directed bench for bcd_time_keeper at CLK_HZ=4, BLINK_DIV=2.
module tb_bcd_time_keeper;
  import bcd_time_keeper_pkg::*;

  localparam int CLK_HZ = 4;

  typedef struct {
    int   hour;
    logic m12;
    int   exp_hr;
    logic exp_pm;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_tick;
  int   pulses;
  int   doubles;
  int   first_i;
  vec_t vecs[10];

  bcd_time_keeper_if tk_if ();

  bcd_time_keeper #(.CLK_HZ(CLK_HZ), .BLINK_DIV(2)) dut (
    .clk   (clk),
    .reset (reset),
    .tk    (tk_if)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int hr_val();
    return int'(tk_if.hr_tens) * 10 + int'(tk_if.hr_ones);
  endfunction

  function automatic int min_val();
    return int'(tk_if.min_tens) * 10 + int'(tk_if.min_ones);
  endfunction

  function automatic int sec_val();
    return int'(tk_if.sec_tens) * 10 + int'(tk_if.sec_ones);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tk_if.btn_mode = 1'b0;
    tk_if.btn_inc = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  task automatic press_mode();
    tk_if.btn_mode = 1'b1;
    step(1);
    tk_if.btn_mode = 1'b0;
    step(1);
  endtask

  task automatic press_inc(input int n);
    repeat (n) begin
      tk_if.btn_inc = 1'b1;
      step(1);
      tk_if.btn_inc = 1'b0;
      step(1);
    end
  endtask

  task automatic wait_ticks(input int n, input string name);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < n * CLK_HZ + 20) begin
      step(1);
      cyc++;
      if (tk_if.sec_tick) seen++;
    end
    check(name, seen, n);
  endtask

  initial begin
    vecs[0] = '{hour: 0,  m12: 1'b0, exp_hr: 0,  exp_pm: 1'b0};
    vecs[1] = '{hour: 0,  m12: 1'b1, exp_hr: 12, exp_pm: 1'b0};
    vecs[2] = '{hour: 12, m12: 1'b1, exp_hr: 12, exp_pm: 1'b1};
    vecs[3] = '{hour: 13, m12: 1'b1, exp_hr: 1,  exp_pm: 1'b1};
    vecs[4] = '{hour: 13, m12: 1'b0, exp_hr: 13, exp_pm: 1'b1};
    vecs[5] = '{hour: 23, m12: 1'b1, exp_hr: 11, exp_pm: 1'b1};
    vecs[6] = '{hour: 9,  m12: 1'b1, exp_hr: 9,  exp_pm: 1'b0};
    vecs[7] = '{hour: 20, m12: 1'b1, exp_hr: 8,  exp_pm: 1'b1};
    vecs[8] = '{hour: 11, m12: 1'b1, exp_hr: 11, exp_pm: 1'b0};
    vecs[9] = '{hour: 22, m12: 1'b1, exp_hr: 10, exp_pm: 1'b1};

    tk_if.mode_12h = 1'b1;
    tk_if.btn_mode = 1'b0;
    tk_if.btn_inc = 1'b0;

    // Reset values, 12 h presentation
    do_reset();
    check("rst12_hr", hr_val(), 12);
    check("rst12_min", min_val(), 0);
    check("rst12_sec", sec_val(), 0);
    check("rst12_pm", int'(tk_if.pm), 0);
    tk_if.mode_12h = 1'b0;
    do_reset();
    check("rst_hr", hr_val(), 0);
    check("rst_edit", int'(tk_if.edit_field), 0);
    check("rst_blink", int'(tk_if.blink), 0);
    check("rst_tick", int'(tk_if.sec_tick), 0);

    // 4*61 cycles of running, plus the output register stage
    pulses = 0;
    doubles = 0;
    prev_tick = 1'b0;
    for (int i = 0; i < CLK_HZ * 61 + 1; i++) begin
      step(1);
      if (tk_if.sec_tick) begin
        pulses++;
        if (prev_tick) doubles++;
      end
      prev_tick = tk_if.sec_tick;
    end
    check("run_pulses", pulses, 61);
    check("run_double_pulse", doubles, 0);
    check("run_sec", sec_val(), 1);
    check("run_min", min_val(), 1);
    check("run_hr", hr_val(), 0);

    // Preload 23:59 by set mode, then run to midnight
    press_mode();
    press_inc(23);
    check("pre_hr", hr_val(), 23);
    check("pre_pm", int'(tk_if.pm), 1);
    press_mode();
    press_inc(58);
    check("pre_min", min_val(), 59);
    check("pre_sec_frozen", sec_val(), 1);
    press_mode();
    check("pre_sec_clr", sec_val(), 0);
    check("pre_edit_run", int'(tk_if.edit_field), 0);
    wait_ticks(59, "pre_wait59");
    check("pre_2359_sec", sec_val(), 59);
    check("pre_2359_hr", hr_val(), 23);
    check("pre_2359_pm", int'(tk_if.pm), 1);
    wait_ticks(1, "pre_wait1");
    check("mid_sec", sec_val(), 0);
    check("mid_min", min_val(), 0);
    check("mid_hr", hr_val(), 0);
    check("mid_pm", int'(tk_if.pm), 0);

    // Hour presentation table
    for (int v = 0; v < 10; v++) begin
      tk_if.mode_12h = 1'b0;
      do_reset();
      press_mode();
      press_inc(vecs[v].hour);
      tk_if.mode_12h = vecs[v].m12;
      step(1);
      check($sformatf("tbl%0d_hr", v), hr_val(), vecs[v].exp_hr);
      check($sformatf("tbl%0d_pm", v), int'(tk_if.pm), int'(vecs[v].exp_pm));
      check($sformatf("tbl%0d_min", v), min_val(), 0);
      check($sformatf("tbl%0d_sec", v), sec_val(), 0);
    end
    tk_if.mode_12h = 1'b0;

    // Edit flow: hours 03, 61 minute incs, return to RUN
    do_reset();
    press_mode();
    check("ed_field_hr", int'(tk_if.edit_field), 1);
    press_inc(3);
    check("ed_hr3", hr_val(), 3);
    press_mode();
    check("ed_field_min", int'(tk_if.edit_field), 2);
    press_inc(61);
    check("ed_min1", min_val(), 1);
    check("ed_hr_nocarry", hr_val(), 3);
    tk_if.btn_mode = 1'b1;
    step(1);
    tk_if.btn_mode = 1'b0;
    first_i = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (i == 1) begin
        check("ed_exit_field", int'(tk_if.edit_field), 0);
        check("ed_exit_sec", sec_val(), 0);
      end
      if (tk_if.sec_tick && first_i == 0) begin
        first_i = i;
        check("ed_first_sec", sec_val(), 1);
      end
    end
    check("ed_first_tick_delay", first_i, CLK_HZ + 1);

    // Same-cycle mode and inc in SET_HR
    do_reset();
    press_mode();
    press_inc(2);
    tk_if.btn_mode = 1'b1;
    tk_if.btn_inc = 1'b1;
    step(1);
    tk_if.btn_mode = 1'b0;
    tk_if.btn_inc = 1'b0;
    step(1);
    check("sim_field", int'(tk_if.edit_field), 2);
    check("sim_hr", hr_val(), 2);
    check("sim_min", min_val(), 0);

    // Reset during SET_MIN with btn_mode held through reset
    do_reset();
    press_mode();
    press_inc(5);
    press_mode();
    press_inc(7);
    check("rm_pre_min", min_val(), 7);
    reset = 1'b1;
    tk_if.btn_mode = 1'b1;
    step(1);
    reset = 1'b0;
    check("rm_hr", hr_val(), 0);
    check("rm_min", min_val(), 0);
    check("rm_field", int'(tk_if.edit_field), 0);
    step(2);
    check("rm_edge_field", int'(tk_if.edit_field), 1);
    step(1);
    check("rm_blink_lo", int'(tk_if.blink), 0);
    step(1);
    check("rm_blink_hi", int'(tk_if.blink), 1);
    check("rm_held_field", int'(tk_if.edit_field), 1);
    tk_if.btn_mode = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
